// File: rtl/fpga_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_cfg_pkg
// Description : Shared configuration constants for the fabric configuration
//               path (config_loader and fpga_seq). Holds the config word
//               widths, the frame sync word, the derived payload length and
//               the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_cfg_pkg;

    // Config word widths, also consumed by fpga_seq
    localparam int SRAM_W = 144;
    localparam int CB_W   = 420;
    localparam int S_W    = 240;
    localparam int SEL_W  = 9;

    // Frame sync word, transmitted MSB first
    localparam logic [7:0] SYNC = 8'hA5;

    // Payload length: every config word back to back
    localparam int CFG_P = SRAM_W + CB_W + S_W + SEL_W;

    // Loader state encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cfg_chk8.sv
`default_nettype none
// ============================================================================
// Module      : cfg_chk8
// Description : 8-lane interleaved XOR accumulator. Lane k holds the XOR of
//               every enabled bit presented with i_lane == k since the last
//               clear.
// Ports       : clk     - rising-edge clock
//               reset   - synchronous active-high reset
//               i_clr   - clear all lanes (wins over i_en)
//               i_en    - fold i_bit into lane i_lane
//               i_bit   - data bit
//               i_lane  - lane index 0..7
//               o_sum   - 8-bit running XOR sum
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_chk8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    input  logic [2:0] i_lane,
    output logic [7:0] o_sum
);

    logic [7:0] r_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum[i_lane] <= r_sum[i_lane] ^ i_bit;
        end
    end

    assign o_sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module      : config_loader
// Description : Serial configuration loader upstream of fpga_seq. Hunts for
//               the frame sync word, shifts the payload into a shadow
//               register while accumulating an 8-lane interleaved checksum,
//               receives the transmitted checksum and, on a match, commits
//               all config words in one cycle. Owns the fabric reset: it is
//               held until a valid configuration has been committed and is
//               reasserted for the duration of every later frame.
// Ports       : clk        - rising-edge clock
//               reset      - synchronous active-high reset
//               cfg_in     - serial config bit
//               cfg_en     - qualifies cfg_in (one bit per enabled cycle)
//               sramConfig - committed SRAM config
//               cbconfig   - committed connection-box config
//               sconfig    - committed switch-box config
//               sel        - committed select word
//               fab_reset  - reset to fpga_seq
//               cfg_busy   - high in LOAD/CHECK/COMMIT
//               cfg_done   - one-cycle pulse on successful commit
//               cfg_err    - one-cycle pulse on checksum mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module config_loader #(
    parameter int         SRAM_W = fpga_cfg_pkg::SRAM_W,
    parameter int         CB_W   = fpga_cfg_pkg::CB_W,
    parameter int         S_W    = fpga_cfg_pkg::S_W,
    parameter int         SEL_W  = fpga_cfg_pkg::SEL_W,
    parameter logic [7:0] SYNC   = fpga_cfg_pkg::SYNC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_in,
    input  logic              cfg_en,
    output logic [SRAM_W-1:0] sramConfig,
    output logic [CB_W-1:0]   cbconfig,
    output logic [S_W-1:0]    sconfig,
    output logic [SEL_W-1:0]  sel,
    output logic              fab_reset,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    import fpga_cfg_pkg::*;

    localparam int                 c_p     = SRAM_W + CB_W + S_W + SEL_W;
    localparam int                 c_cnt_w = $clog2(c_p);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_p - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_next;
    logic [6:0]          r_hunt;      // previous 7 enabled bits seen in IDLE
    logic [c_cnt_w-1:0]  r_cnt;       // payload bit index
    logic [c_p-1:0]      r_shadow;
    logic [7:0]          r_rx_chk;
    logic [2:0]          r_chk_idx;
    logic                r_loaded;
    logic                r_fab_reset;
    logic                r_done;
    logic                r_err;
    logic [SRAM_W-1:0]   r_sram;
    logic [CB_W-1:0]     r_cb;
    logic [S_W-1:0]      r_s;
    logic [SEL_W-1:0]    r_sel;

    logic [7:0]          w_run_chk;
    logic                w_match;
    logic                w_start;
    logic                w_load_en;
    logic                w_load_last;
    logic                w_chk_en;
    logic                w_chk_last;
    logic                w_good;

    // The sync compare includes the current bit so the match edge itself
    // is the transition into LOAD.
    assign w_match     = cfg_en && ({r_hunt, cfg_in} == SYNC);
    assign w_start     = (r_state == IDLE) && w_match;
    assign w_load_en   = (r_state == LOAD) && cfg_en;
    assign w_load_last = w_load_en && (r_cnt == c_last);
    assign w_chk_en    = (r_state == CHECK) && cfg_en;
    assign w_chk_last  = w_chk_en && (r_chk_idx == 3'd7);
    assign w_good      = (r_rx_chk == w_run_chk);

    // ------------------------------------------------------------------
    // Running payload checksum: lane = payload index mod 8
    // ------------------------------------------------------------------
    cfg_chk8 u_chk (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_start),
        .i_en   (w_load_en),
        .i_bit  (cfg_in),
        .i_lane (r_cnt[2:0]),
        .o_sum  (w_run_chk)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A deasserted cfg_en simply holds the current state;
    // COMMIT always lasts exactly one cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_match)     w_next = LOAD;
            LOAD:    if (w_load_last) w_next = CHECK;
            CHECK:   if (w_chk_last)  w_next = COMMIT;
            COMMIT:                   w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hunt      <= '0;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_rx_chk    <= '0;
            r_chk_idx   <= '0;
            r_loaded    <= 1'b0;
            r_fab_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_sram      <= '0;
            r_cb        <= '0;
            r_s         <= '0;
            r_sel       <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg_en) begin
                        if (w_match) begin
                            r_hunt      <= '0;
                            r_cnt       <= '0;
                            r_chk_idx   <= '0;
                            r_fab_reset <= 1'b1;
                        end else begin
                            r_hunt <= {r_hunt[5:0], cfg_in};
                        end
                    end
                end
                LOAD: begin
                    if (cfg_en) begin
                        r_shadow <= {r_shadow[c_p-2:0], cfg_in};
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (cfg_en) begin
                        r_rx_chk  <= {r_rx_chk[6:0], cfg_in};
                        r_chk_idx <= r_chk_idx + 1'b1;
                    end
                end
                COMMIT: begin
                    if (w_good) begin
                        // First-arriving bits sit at the top of the shadow
                        r_sram      <= r_shadow[c_p-1 -: SRAM_W];
                        r_cb        <= r_shadow[CB_W+S_W+SEL_W-1 -: CB_W];
                        r_s         <= r_shadow[S_W+SEL_W-1 -: S_W];
                        r_sel       <= r_shadow[SEL_W-1:0];
                        r_done      <= 1'b1;
                        r_loaded    <= 1'b1;
                        r_fab_reset <= 1'b0;
                    end else begin
                        // Previous config stays live; fabric is released
                        // again only if a valid config was ever committed.
                        r_err       <= 1'b1;
                        r_fab_reset <= !r_loaded;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sramConfig = r_sram;
    assign cbconfig   = r_cb;
    assign sconfig    = r_s;
    assign sel        = r_sel;
    assign fab_reset  = r_fab_reset;
    assign cfg_busy   = (r_state != IDLE);
    assign cfg_done   = r_done;
    assign cfg_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_loader
// Description : Self-checking bench for config_loader. A table of frame
//               records (payload, cfg_en gap rate, checksum corruption,
//               expected result) is applied in order, followed by
//               hand-written sync-hunt and mid-frame-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_loader;

    import fpga_cfg_pkg::*;

    localparam int P = CFG_P;

    typedef logic [P-1:0] payload_t;

    typedef struct {
        int pay_sel;    // 0 = zero, 1 = payload A, 2 = payload B
        int gap;        // percentage of cycles with cfg_en low
        bit corrupt;    // flip chk[3]
        bit good;       // expect cfg_done (else cfg_err)
        int exp_sel;    // payload expected on the outputs afterwards
        bit exp_fab;    // fab_reset expected afterwards
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_in;
    logic              cfg_en;
    logic [SRAM_W-1:0] sramConfig;
    logic [CB_W-1:0]   cbconfig;
    logic [S_W-1:0]    sconfig;
    logic [SEL_W-1:0]  sel;
    logic              fab_reset;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;

    config_loader dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_in     (cfg_in),
        .cfg_en     (cfg_en),
        .sramConfig (sramConfig),
        .cbconfig   (cbconfig),
        .sconfig    (sconfig),
        .sel        (sel),
        .fab_reset  (fab_reset),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int       n_cmp = 0;
    int       n_bad = 0;
    int       edge_cnt = 0;
    int       gap_pct = 0;
    payload_t pay_a;
    payload_t pay_b;
    vec_t     tbl[5];

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    function automatic payload_t pick(input int k);
        if (k == 1) return pay_a;
        if (k == 2) return pay_b;
        return '0;
    endfunction

    // Reference checksum: lane k = XOR of payload bits whose arrival index
    // is congruent to k mod 8. Arrival index i is vector bit P-1-i.
    function automatic logic [7:0] calc_chk(input payload_t p);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < P; i++) c[i % 8] = c[i % 8] ^ p[P-1-i];
        return c;
    endfunction

    // One enabled bit, preceded by a random number of disabled cycles
    task automatic send_bit(input logic b);
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            cfg_en = 1'b0;
            cfg_in = 1'($urandom_range(1));
            tick();
        end
        cfg_en = 1'b1;
        cfg_in = b;
        tick();
    endtask

    task automatic check_outputs(input string tag, input payload_t e, input logic fab);
        check({tag, ".sram"}, 512'(sramConfig), 512'(e[P-1 -: SRAM_W]));
        check({tag, ".cb"},   512'(cbconfig),   512'(e[CB_W+S_W+SEL_W-1 -: CB_W]));
        check({tag, ".s"},    512'(sconfig),    512'(e[S_W+SEL_W-1 -: S_W]));
        check({tag, ".sel"},  512'(sel),        512'(e[SEL_W-1:0]));
        check({tag, ".fab"},  512'(fab_reset),  512'(fab));
    endtask

    // Sends prefix (last bit completes the sync), payload and checksum,
    // then checks the COMMIT cycle and the result pulses.
    task automatic send_frame(input string tag, input payload_t p,
                              input logic [15:0] pre, input int pre_len,
                              input int gap, input bit corrupt,
                              input bit exp_good, input payload_t exp_out,
                              input bit exp_fab);
        logic [7:0] c;
        gap_pct  = gap;
        edge_cnt = 0;
        for (int j = pre_len - 1; j >= 0; j--) begin
            send_bit(pre[j]);
            check({tag, ".busy_pre"}, 512'(cfg_busy), 512'(j == 0));
        end
        check({tag, ".fab_load"}, 512'(fab_reset), 512'(1'b1));
        for (int i = 0; i < P; i++) begin
            send_bit(p[P-1-i]);
            if (i == P / 2) begin
                check({tag, ".busy_mid"}, 512'(cfg_busy), 512'(1'b1));
                check({tag, ".done_mid"}, 512'(cfg_done), 512'(1'b0));
            end
        end
        c = calc_chk(p);
        if (corrupt) c[3] = ~c[3];
        for (int j = 7; j >= 0; j--) send_bit(c[j]);
        // COMMIT cycle: results not yet visible; an enabled bit here is dropped
        check({tag, ".busy_commit"}, 512'(cfg_busy), 512'(1'b1));
        check({tag, ".done_early"},  512'(cfg_done), 512'(1'b0));
        cfg_en = 1'b1;
        cfg_in = 1'b1;
        tick();
        cfg_en = 1'b0;
        check({tag, ".done"}, 512'(cfg_done), 512'(exp_good));
        check({tag, ".err"},  512'(cfg_err),  512'(!exp_good));
        check({tag, ".busy_after"}, 512'(cfg_busy), 512'(1'b0));
        if (gap == 0) check({tag, ".latency"}, 512'(edge_cnt), 512'(pre_len + 822));
        check_outputs(tag, exp_out, exp_fab);
        tick();
        check({tag, ".done_pulse"}, 512'(cfg_done), 512'(1'b0));
        check({tag, ".err_pulse"},  512'(cfg_err),  512'(1'b0));
        check_outputs({tag, ".hold"}, exp_out, exp_fab);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] sync16;
        logic [15:0] hunt16;

        reset  = 1'b1;
        cfg_en = 1'b0;
        cfg_in = 1'b0;

        // Down-counter payload: sramConfig top 32 = 0x0006_0001, cbconfig
        // top 35 bits given, sconfig 0, sel all ones.
        pay_a = '0;
        pay_a[P-1 -: 32] = 32'h0006_0001;
        pay_a[CB_W+S_W+SEL_W-1 -: 35] = 35'b1100000_0000011_0000101_0001001_0010001;
        pay_a[SEL_W-1:0] = 9'h1FF;

        // Irregular pattern touching every field
        for (int i = 0; i < P; i++) pay_b[i] = (((i * 37) % 11) < 5);

        sync16 = 16'(SYNC);
        hunt16 = 16'b0000_000_0_1010_0101;  // noise 0x52 then 1: sync one bit late

        tbl[0] = '{pay_sel: 1, gap: 0,  corrupt: 1'b1, good: 1'b0, exp_sel: 0, exp_fab: 1'b1};
        tbl[1] = '{pay_sel: 1, gap: 0,  corrupt: 1'b0, good: 1'b1, exp_sel: 1, exp_fab: 1'b0};
        tbl[2] = '{pay_sel: 2, gap: 0,  corrupt: 1'b1, good: 1'b0, exp_sel: 1, exp_fab: 1'b0};
        tbl[3] = '{pay_sel: 2, gap: 0,  corrupt: 1'b0, good: 1'b1, exp_sel: 2, exp_fab: 1'b0};
        tbl[4] = '{pay_sel: 1, gap: 40, corrupt: 1'b0, good: 1'b1, exp_sel: 1, exp_fab: 1'b0};

        // Reset state
        repeat (3) tick();
        check_outputs("reset", '0, 1'b1);
        check("reset.busy", 512'(cfg_busy), 512'(1'b0));
        check("reset.done", 512'(cfg_done), 512'(1'b0));
        check("reset.err",  512'(cfg_err),  512'(1'b0));
        reset = 1'b0;
        tick();

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            send_frame($sformatf("vec%0d", v), pick(tbl[v].pay_sel), sync16, 8,
                       tbl[v].gap, tbl[v].corrupt, tbl[v].good,
                       pick(tbl[v].exp_sel), tbl[v].exp_fab);
            repeat (3) tick();
        end

        // Sync hunt: 0x52 alone must not lock; the trailing 1 completes A5
        send_frame("hunt", pay_b, hunt16, 9, 0, 1'b0, 1'b1, pay_b, 1'b0);
        repeat (2) tick();

        // Reset in the middle of a frame at payload bit 400
        gap_pct = 0;
        for (int j = 7; j >= 0; j--) send_bit(sync16[j]);
        for (int i = 0; i < 400; i++) send_bit(pay_a[P-1-i]);
        check("midrst.fab_before", 512'(fab_reset), 512'(1'b1));
        check("midrst.busy_before", 512'(cfg_busy), 512'(1'b1));
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        cfg_en = 1'b0;
        check_outputs("midrst", '0, 1'b1);
        check("midrst.busy", 512'(cfg_busy), 512'(1'b0));
        check("midrst.done", 512'(cfg_done), 512'(1'b0));
        tick();
        send_frame("after_rst", pay_a, sync16, 8, 0, 1'b0, 1'b1, pay_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
